// File: rtl/inertial_pkg.sv
// Shared constants and types for the inertial-delay filter controller.
package inertial_pkg;

    localparam int CH_DEF          = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DLY_DEF = 5;
    localparam int CH_W            = $clog2(CH_DEF);

    // One accepted output transition: which channel moved and its new level.
    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            level;
    } evt_t;

    // Next channel index after idx, wrapping at n (n need not be a power of two).
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/inertial_chan.sv
// One filtered channel: counts consecutive cycles where the input disagrees
// with the output and flips the output once that run reaches the delay.
module inertial_chan
    import inertial_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_din,
    input  logic [CNT_W-1:0] i_eff,
    input  logic             i_clr,
    output logic             o_dout,
    output logic             o_chg
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             w_diff;
    logic             w_fire;

    assign w_diff = (i_din != r_dout);
    // A delay reload restarts timing, so it also suppresses the flip on that edge.
    assign w_fire = w_diff && !i_clr && (r_cnt == i_eff - 1'b1);

    // Run-length counter and output register; agreement or reload clears the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else if (i_clr || !w_diff) begin
            r_cnt <= '0;
        end else if (w_fire) begin
            r_dout <= i_din;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_dout = r_dout;
    assign o_chg  = w_fire;

endmodule

// File: rtl/inertial_filter_ctrl.sv
// Multi-channel inertial-delay filter. Accepted output transitions are held
// one-deep per channel and drained round-robin onto a valid/ready event port.
//
// Event port handshake: an event transfers on a clock edge where evt_valid
// and evt_ready are both 1. While evt_valid=1 and evt_ready=0, evt_ch and
// evt_level do not change; evt_ready is ignored while evt_valid=0.
module inertial_filter_ctrl
    import inertial_pkg::*;
#(
    parameter int CH          = CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DLY = DEFAULT_DLY_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         din,
    input  logic                  cfg_we,
    input  logic [CNT_W-1:0]      cfg_dly,
    input  logic                  ovf_clr,
    output logic [CH-1:0]         dout,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [$clog2(CH)-1:0] evt_ch,
    output logic                  evt_level,
    output logic [CH-1:0]         ovf
);

    localparam int CHW = $clog2(CH);

    logic [CNT_W-1:0] r_dly;
    logic [CNT_W-1:0] w_eff;
    logic [CH-1:0]    w_dout;
    logic [CH-1:0]    w_chg;
    logic [CH-1:0]    r_pending;
    logic [CH-1:0]    r_plevel;
    logic [CH-1:0]    r_ovf;
    logic [CH-1:0]    w_unload;
    logic [CH-1:0]    w_ovf_set;
    logic [CHW-1:0]   r_ptr;
    logic [CHW-1:0]   w_win;
    logic [CHW-1:0]   r_evt_ch;
    logic             w_any;
    logic             w_load;
    logic             r_evt_valid;
    logic             r_evt_level;

    // A programmed delay of zero behaves as one cycle.
    assign w_eff = (r_dly == '0) ? CNT_W'(1) : r_dly;

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        inertial_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_din  (din[gi]),
            .i_eff  (w_eff),
            .i_clr  (cfg_we),
            .o_dout (w_dout[gi]),
            .o_chg  (w_chg[gi])
        );
    end

    // Round-robin pick: first pending channel at or after the pointer, wrapping.
    always_comb begin
        int idx;
        w_win = '0;
        w_any = 1'b0;
        idx   = 0;
        for (int k = 0; k < CH; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            if (!w_any && r_pending[idx]) begin
                w_any = 1'b1;
                w_win = CHW'(idx);
            end
        end
    end

    assign w_load    = (!r_evt_valid || evt_ready) && w_any;
    assign w_unload  = w_load ? (CH'(1) << w_win) : '0;
    // A fresh change on a slot still occupied (and not leaving now) loses the old event.
    assign w_ovf_set = w_chg & r_pending & ~w_unload;

    // Delay register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= CNT_W'(DEFAULT_DLY);
        end else if (cfg_we) begin
            r_dly <= cfg_dly;
        end
    end

    // Per-channel event slots; a new change re-arms a slot even as it unloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_plevel  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_unload) | w_chg;
            r_plevel  <= (r_plevel & ~w_chg) | (din & w_chg);
        end
    end

    // Sticky overflow flags; a new overflow outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{CH{ovf_clr}}) | w_ovf_set;
        end
    end

    // Event output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_level <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_evt_valid <= 1'b1;
            r_evt_ch    <= w_win;
            r_evt_level <= r_plevel[w_win];
            r_ptr       <= CHW'(next_idx(int'(w_win), CH));
        end else if (evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign dout      = w_dout;
    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign evt_level = r_evt_level;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_inertial_filter_ctrl.sv
// Self-checking bench for inertial_filter_ctrl with a behavioural reference model.
module tb_inertial_filter_ctrl;
    import inertial_pkg::*;

    localparam int CH    = CH_DEF;
    localparam int CNT_W = CNT_W_DEF;
    localparam int SW    = 2 * CH + CH_W + 2;

    // ---------------- clock / reset / DUT ----------------
    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [CH-1:0]    din       = '0;
    logic             cfg_we    = 1'b0;
    logic [CNT_W-1:0] cfg_dly   = '0;
    logic             ovf_clr   = 1'b0;
    logic             evt_ready = 1'b0;
    logic [CH-1:0]    dout;
    logic             evt_valid;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_level;
    logic [CH-1:0]    ovf;

    always #5 clk = ~clk;

    inertial_filter_ctrl #(
        .CH          (CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DLY (DEFAULT_DLY_DEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .cfg_we    (cfg_we),
        .cfg_dly   (cfg_dly),
        .ovf_clr   (ovf_clr),
        .dout      (dout),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level),
        .ovf       (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Each channel remembers how many edges in a row the input has disagreed
    // with the filtered output; each channel owns a one-deep mailbox of its
    // latest accepted level; a single presented event drains mailboxes in
    // rotating order.
    logic [CH-1:0]   m_dout, m_pend, m_plev, m_ovf;
    int              m_run[CH];
    int              m_dly;
    int              m_ptr;
    logic            m_valid;
    logic [CH_W-1:0] m_ch;
    logic            m_lev;
    evt_t            exp_q[$];
    evt_t            got_q[$];

    task automatic model_reset();
        m_dout  = '0;
        m_pend  = '0;
        m_plev  = '0;
        m_ovf   = '0;
        m_dly   = DEFAULT_DLY_DEF;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_ch    = '0;
        m_lev   = 1'b0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        int            eff;
        int            win;
        int            c;
        logic          load;
        logic [CH-1:0] chg;
        evt_t          e;
        eff = (m_dly == 0) ? 1 : m_dly;
        win = -1;
        for (int k = 0; k < CH; k++) begin
            c = (m_ptr + k) % CH;
            if (win < 0 && m_pend[c]) win = c;
        end
        load = (!m_valid || evt_ready) && (win >= 0);
        if (m_valid && evt_ready) begin
            e.ch    = m_ch;
            e.level = m_lev;
            exp_q.push_back(e);
        end
        chg = '0;
        for (int i = 0; i < CH; i++) begin
            if (cfg_we || din[i] == m_dout[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= eff) begin
                    m_dout[i] = din[i];
                    m_run[i]  = 0;
                    chg[i]    = 1'b1;
                end
            end
        end
        if (load) begin
            m_valid    = 1'b1;
            m_ch       = CH_W'(win);
            m_lev      = m_plev[win];
            m_pend[win] = 1'b0;
            m_ptr      = (win + 1) % CH;
        end else if (evt_ready) begin
            m_valid = 1'b0;
        end
        if (ovf_clr) m_ovf = '0;
        for (int i = 0; i < CH; i++) begin
            if (chg[i]) begin
                if (m_pend[i]) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_plev[i] = m_dout[i];
            end
        end
        if (cfg_we) m_dly = int'(cfg_dly);
    endtask

    function automatic logic [SW-1:0] dut_vec();
        return {dout, evt_valid, evt_ch, evt_level, ovf};
    endfunction

    function automatic logic [SW-1:0] model_vec();
        return {m_dout, m_valid, m_ch, m_lev, m_ovf};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        evt_t e;
        if (rst_n && evt_valid && evt_ready) begin
            e.ch    = evt_ch;
            e.level = evt_level;
            got_q.push_back(e);
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic load_dly(input int d);
        cfg_we  = 1'b1;
        cfg_dly = CNT_W'(d);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_queues();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din       = CH'($urandom);
        evt_ready = 1'b1;
        #2;
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec(), SW'(0));
        end
        tick();
        tick();
        din   = '0;
        rst_n = 1'b1;
        clear_queues();
        tick();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_accept();
        evt_t e;
        clear_queues();
        evt_ready = 1'b1;
        din       = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_cmp++;
            if (dout[0] !== (c >= 5)) begin
                n_bad++;
                $display("FAIL accept_dout0 edge %0d: got %b want %b", c, dout[0], (c >= 5));
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL accept_state edge %0d: got %h want %h", c, dut_vec(), model_vec());
            end
        end
        e.ch    = 0;
        e.level = 1'b1;
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== e) begin
            n_bad++;
            $display("FAIL accept_event: got %0d events first %h want 1 event %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : evt_t'(0), e);
        end
        n_cmp++;
        if (ovf !== '0) begin
            n_bad++;
            $display("FAIL accept_ovf: got %b want 0", ovf);
        end
    endtask

    task automatic test_reject();
        clear_queues();
        for (int c = 0; c < 10; c++) begin
            din[1] = (c < 4);
            tick();
            n_cmp++;
            if (dout[1] !== 1'b0 || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL reject_dout1 cycle %0d: got %h want %h (dout1=0)", c, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL reject_events: got %0d want 0", got_q.size());
        end
    endtask

    task automatic test_dly0();
        evt_t e;
        clear_queues();
        load_dly(0);
        din[2] = 1'b1;
        tick();
        n_cmp++;
        if (dout[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL dly0_latency: got %b want 1", dout[2]);
        end
        for (int c = 0; c < 4; c++) tick();
        e.ch    = 2;
        e.level = 1'b1;
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== e) begin
            n_bad++;
            $display("FAIL dly0_event: got %0d events want 1 event %h", got_q.size(), e);
        end
    endtask

    task automatic test_back_to_back();
        evt_t e;
        pulse_reset();
        load_dly(0);
        evt_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            clear_queues();
            din = (pass == 0) ? 4'b1111 : 4'b0000;
            for (int c = 0; c < 7; c++) begin
                tick();
                n_cmp++;
                if (dut_vec() !== model_vec()) begin
                    n_bad++;
                    $display("FAIL b2b_state pass %0d cycle %0d: got %h want %h", pass, c, dut_vec(), model_vec());
                end
            end
            n_cmp++;
            if (got_q.size() != CH) begin
                n_bad++;
                $display("FAIL b2b_count pass %0d: got %0d want %0d", pass, got_q.size(), CH);
            end
            for (int k = 0; k < CH && k < got_q.size(); k++) begin
                e.ch    = CH_W'(k);
                e.level = (pass == 0);
                n_cmp++;
                if (got_q[k] !== e) begin
                    n_bad++;
                    $display("FAIL b2b_order pass %0d slot %0d: got %h want %h", pass, k, got_q[k], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        evt_t e;
        clear_queues();
        evt_ready = 1'b0;
        din       = 4'b0001;
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) din[3] = ~din[3];
            tick();
            n_cmp++;
            if ({evt_valid, evt_ch, evt_level} !== {1'b1, CH_W'(0), 1'b1}) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: got %b_%0d_%b want 1_0_1", c, evt_valid, evt_ch, evt_level);
            end
        end
        n_cmp++;
        if (ovf !== 4'b1000) begin
            n_bad++;
            $display("FAIL bp_ovf: got %b want 1000", ovf);
        end
        evt_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL bp_count: got %0d want 2", got_q.size());
        end else begin
            e.ch    = 3;
            e.level = 1'b1;
            n_cmp++;
            if (got_q[1] !== e) begin
                n_bad++;
                $display("FAIL bp_coalesced: got %h want %h", got_q[1], e);
            end
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== '0) begin
            n_bad++;
            $display("FAIL bp_ovf_clr: got %b want 0", ovf);
        end
    endtask

    task automatic test_cfg_restart();
        clear_queues();
        load_dly(5);
        din[1] = 1'b1;
        tick();
        tick();
        load_dly(5);
        n_cmp++;
        if (dout[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_no_flip: got %b want 0", dout[1]);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (dout[1] !== (c == 5) || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL cfg_restart edge %0d: got dout1=%b state %h want dout1=%b state %h",
                         c, dout[1], dut_vec(), (c == 5), model_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        load_dly(0);
        din = ~din;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL midreset_async: got %h want %h", dut_vec(), SW'(0));
        end
        @(negedge clk);
        din       = '0;
        evt_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        clear_queues();
        for (int c = 0; c < 6; c++) tick();
        n_cmp++;
        if (got_q.size() != 0 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL midreset_flush: got %0d events state %h want 0 events state %h",
                     got_q.size(), dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            cfg_we  = ($urandom_range(0, 59) == 0);
            cfg_dly = CNT_W'($urandom_range(0, 4));
            ovf_clr = ($urandom_range(0, 39) == 0);
            evt_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 3) == 0) din[i] = ~din[i];
            end
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random_state cycle %0d: got %h want %h", c, dut_vec(), model_vec());
            end
        end
        cfg_we    = 1'b0;
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        for (int c = 0; c < 40; c++) tick();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_event_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL random_event %0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_accept();
        test_reject();
        test_dly0();
        test_back_to_back();
        test_backpressure();
        test_cfg_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inertial_filter_ctrl.md
Name: inertial_filter_ctrl

Overview:
- Clocked, synthesizable multi-channel inertial-delay controller.
- Each channel propagates its input to its output only after the input has differed from the output for a programmable number of consecutive clock cycles. Shorter pulses are rejected, which is the clocked equivalent of an inertial delay.
- Every accepted output transition is queued as an event and drained through a round-robin arbiter onto a single valid/ready event port for a downstream logger or interrupt block.

Parameters:
- CH, 4: number of filtered channels (2..16).
- CNT_W, 8: width of the delay register and of the per-channel counters.
- DEFAULT_DLY, 5: delay in cycles loaded at reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  CH  raw channel inputs; synchronous to clk.
- cfg_we  input  1  load cfg_dly into the delay register.
- cfg_dly  input  CNT_W  new delay value.
- ovf_clr  input  1  clear all ovf bits.
- dout  output  CH  filtered channel outputs.
- evt_valid  output  1  event available.
- evt_ready  input  1  consumer accepts event.
- evt_ch  output  $clog2(CH)  channel of the presented event.
- evt_level  output  1  new dout level of that channel.
- ovf  output  CH  sticky flag: an event on that channel was lost by coalescing.

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, all counters=0, dly=DEFAULT_DLY, pending=0.
  - evt_valid=0, evt_ch=0, evt_level=0, ovf=0.
  - Round-robin pointer=0.
- Effective delay: eff = (dly==0) ? 1 : dly.
- Per channel i, at each clock edge:
  - din[i]==dout[i]: cnt<=0. This is the idle/reject path.
  - din[i]!=dout[i] and cnt==eff-1: dout[i]<=din[i], cnt<=0, raise change event.
  - Otherwise: cnt<=cnt+1.
- Latency and rejection:
  - A level held for eff consecutive sampled edges appears on dout immediately after the eff-th edge.
  - A pulse of fewer than eff cycles never reaches dout.
  - With eff=1, dout follows din with one cycle of latency.
- Config:
  - cfg_we=1 updates dly at that edge.
  - All counters clear at the same edge, so pending transitions restart timing under the new delay.
  - dout is unchanged by cfg_we.
- Event capture: a change event sets pending[i] and records plevel[i]=new dout[i].
  - If pending[i] is already set and not being unloaded that cycle: plevel is overwritten and ovf[i]<=1.
  - ovf_clr clears ovf. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Event output register:
  - Loads when (!evt_valid || evt_ready) and any pending bit is set.
  - Winner = first pending channel searching from the pointer upward, modulo CH.
  - On load: evt_valid=1, evt_ch=winner, evt_level=plevel[winner], pending[winner] cleared, pointer<=winner+1 mod CH.
  - If the winner raises a new change in the same cycle it is loaded, pending[winner] stays set with the new level. No ovf in this case.
  - If nothing is pending and evt_ready=1, evt_valid drops to 0.
- Handshake:
  - evt_ch and evt_level are stable while evt_valid=1 and evt_ready=0.
  - evt_ready has no effect while evt_valid=0.
  - Back-to-back transfers occur at one per cycle.
- Reset mid-operation discards all pending events, the presented event and counter state immediately.

Decomposition:
- Package inertial_pkg holds:
  - defaults CH_DEF=4, CNT_W_DEF=8, DEFAULT_DLY_DEF=5;
  - CH_W=$clog2(CH);
  - an event struct {ch, level}.
- Sub-module inertial_chan: one channel's counter, compare and dout register, plus its change-event strobe. It is instantiated CH times.
- Arbiter, pending/plevel/ovf logic and the event output register stay in the top level.

Test Plan:
- Reset, then din[0] 0→1 held 10 cycles, dly=5, evt_ready=1 -> dout[0] rises after the 5th edge; one event {ch=0, level=1}; ovf=0.
- din[1] high for 4 cycles only, dly=5 -> dout[1] stays 0; no event.
- cfg_we with cfg_dly=0, then din[2] 0→1 -> dout[2]=1 one cycle later; event {2,1}.
- All four channels transition on the same edge, evt_ready=1 -> events delivered in order ch0, ch1, ch2, ch3 on consecutive cycles. A further simultaneous toggle is then delivered starting at ch0, because the pointer is 0 after granting ch3.
- evt_ready=0 while ch3 toggles 1→0→1 (dly=1) and another event is presented -> presented event held stable; ovf[3]=1; a single {3,1} is delivered later; ovf_clr then sets ovf=0.
- cfg_we pulsed at cycle 3 of a 5-cycle pending transition -> counter restarts, and dout changes only after 5 further cycles of din≠dout.
